vec_ls_sequencer: RTL
=====================

Name: vec_ls_sequencer

Overview:
Controller that sequences the 4-lane vector datapath (VRF, X1/X2 staging registers, T0–T3 lane registers, lane memory mux) for multi-cycle vector operations.
- Supported operations: vector load (VLOAD), vector store (VSTORE) and vector add (VADD).
- The 8-bit data memory needs one access per lane, so the block walks a lane counter, generates lane addresses, and steers the lane load and mux selects.
- The main control FSM hands off via start/op and waits on done.

Parameters:
STRIDE, 1, address increment between consecutive lanes (8-bit, modulo 256)
LANES, 4, lane count; fixed at 4, other values unsupported

Ports:
clock  in  1  system clock, all state changes on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  request pulse; sampled only in IDLE
op  in  2  00=VLOAD, 01=VSTORE, 10=VADD, 11=reserved
base_addr  in  8  lane-0 memory address; latched on accepted start
busy  out  1  high from first cycle after accepted start through the done cycle
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse on reserved op
mem_addr  out  8  memory address for current lane
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_in_sel  out  3  memory write-data mux select, 0..3 = X1 lane 0..3 (value 4 never driven)
x1_load  out  1  X1 staging register enable
x2_load  out  1  X2 staging register enable
vout_sel  out  1  T-register input select, 1=memory, 0=lane adders
t_ld  out  4  T0..T3 load enables, bit i = Ti
vrf_write  out  1  VRF write enable

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, lane counter=0, latched address=0, and every output 0, including mem_addr and mem_in_sel. Outputs are registered or decoded from registered state only; no combinational path from start or op.
- States: IDLE, RD, CAP, WB, LDX, WR, ADDX, ADDT, ADDWB. The lane counter is 2 bits.
- Accept condition: start=1 in IDLE. base_addr and op are latched on that edge. start is ignored in all other states.
- Cycle numbering: the accepted start edge ends cycle 0.
- VLOAD, states RD(lanes 0–3) → CAP → WB:
  - Cycles 1–4: mem_read=1, mem_addr=base+i*STRIDE.
  - Memory read latency is 1 cycle, so t_ld[i-1]=1 with vout_sel=1 in cycles 2–4.
  - Cycle 5 (CAP): t_ld[3]=1, vout_sel=1, mem_read=0.
  - Cycle 6 (WB): vrf_write=1 and done=1, then IDLE. busy is high in cycles 1–6.
- VSTORE, states LDX → WR(lanes 0–3):
  - Cycle 1: x1_load=1.
  - Cycles 2–5: mem_write=1, mem_in_sel=i, mem_addr=base+i*STRIDE.
  - done=1 in cycle 5, then IDLE. busy is high in cycles 1–5.
- VADD, states ADDX → ADDT → ADDWB:
  - Cycle 1: x1_load=x2_load=1.
  - Cycle 2: t_ld=4'b1111, vout_sel=0.
  - Cycle 3: vrf_write=1, done=1, then IDLE.
- Reserved op=11: err=1 for one cycle (cycle 1). busy, done and all strobes stay 0, and the block remains in IDLE.
- Address arithmetic: 8-bit with wrap-around, e.g. base=0xFE with STRIDE=1 gives FE, FF, 00, 01.
- Exclusivity:
  - mem_read and mem_write are never high together.
  - vrf_write is never high together with any t_ld bit.
  - Outside the cycles listed above, all strobes are 0, vout_sel=0, mem_in_sel=0 and mem_addr=0.
- Back-to-back operation: start asserted in the done cycle is ignored. The earliest accept is the first IDLE cycle after done.
- Reset mid-operation: return to IDLE immediately with all outputs deasserted. vrf_write and mem_write must never fire for the aborted operation. Partial T-register contents are don't-care.

Test Plan:
1. Reset held low with start=1 and op=00 → all outputs 0. Release reset and pulse start with op=00, base=0x10 → mem_read in cycles 1–4 with addresses 10, 11, 12, 13; t_ld 0001, 0010, 0100 in cycles 2–4; 1000 in cycle 5; vrf_write and done in cycle 6.
2. VSTORE with base=0x20 and STRIDE=2 → x1_load in cycle 1; mem_write in cycles 2–5 with addr 20, 22, 24, 26 and mem_in_sel 0, 1, 2, 3; done in cycle 5; mem_read never 1.
3. VADD → x1_load and x2_load in cycle 1, t_ld=1111 with vout_sel=0 in cycle 2, vrf_write and done in cycle 3. With a datapath model, lanes 0x7F+0x02 and 0xFF+0x01 write back 0x81 and 0x00.
4. VLOAD with base=0xFE → addresses FE, FF, 00, 01 (wrap-around).
5. op=11 → err pulse in cycle 1 only, busy=0; a second start with op=00 while busy, and another in the done cycle, are both ignored (exactly one done per accepted op).
6. Assert reset in cycle 3 of VLOAD and of VSTORE → outputs go 0 asynchronously, no vrf_write and no further mem_write. After release, a fresh VADD completes normally in 3 cycles.

Source files
------------

// File: rtl/vec_ls_sequencer.sv
// Lane sequencer for the 4-lane vector datapath: walks lanes for VLOAD/VSTORE
// and steps the VADD pipeline, driving memory, staging, lane and VRF controls.
module vec_ls_sequencer #(
   parameter int unsigned STRIDE = 1,
   parameter int unsigned LANES  = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [1:0] op,
   input  logic [7:0] base_addr,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [7:0] mem_addr,
   output logic       mem_read,
   output logic       mem_write,
   output logic [2:0] mem_in_sel,
   output logic       x1_load,
   output logic       x2_load,
   output logic       vout_sel,
   output logic [3:0] t_ld,
   output logic       vrf_write
);

   localparam int unsigned LANE_W = $clog2(LANES);
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

   localparam logic [1:0] OP_VLOAD  = 2'b00;
   localparam logic [1:0] OP_VSTORE = 2'b01;
   localparam logic [1:0] OP_VADD   = 2'b10;

   typedef enum logic [3:0] {
      S_IDLE, S_RD, S_CAP, S_WB, S_LDX, S_WR, S_ADDX, S_ADDT, S_ADDWB
   } state_t;

   state_t              state_q, state_d;
   logic [LANE_W-1:0]   lane_q, lane_d;
   logic [7:0]          base_q, base_d;
   logic [7:0]          lane_addr;

   logic       busy_d, done_d, err_d, mem_read_d, mem_write_d;
   logic       x1_load_d, x2_load_d, vout_sel_d, vrf_write_d;
   logic [7:0] mem_addr_d;
   logic [2:0] mem_in_sel_d;
   logic [3:0] t_ld_d;

   // Next state, then the outputs decoded from the state being entered so
   // they can be registered and line up with that state's cycle.
   always_comb begin
      state_d      = state_q;
      lane_d       = lane_q;
      base_d       = base_q;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      err_d        = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_addr_d   = 8'h00;
      mem_in_sel_d = 3'd0;
      x1_load_d    = 1'b0;
      x2_load_d    = 1'b0;
      vout_sel_d   = 1'b0;
      t_ld_d       = 4'b0000;
      vrf_write_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               base_d = base_addr;
               lane_d = '0;
               case (op)
                  OP_VLOAD:  state_d = S_RD;
                  OP_VSTORE: state_d = S_LDX;
                  OP_VADD:   state_d = S_ADDX;
                  default:   err_d   = 1'b1;
               endcase
            end
         end
         S_RD: begin
            lane_d = lane_q + LANE_W'(1);
            if (lane_q == LAST_LANE) state_d = S_CAP;
         end
         S_CAP:   state_d = S_WB;
         S_WB:    state_d = S_IDLE;
         S_LDX:   state_d = S_WR;
         S_WR: begin
            lane_d = lane_q + LANE_W'(1);
            if (lane_q == LAST_LANE) state_d = S_IDLE;
         end
         S_ADDX:  state_d = S_ADDT;
         S_ADDT:  state_d = S_ADDWB;
         S_ADDWB: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      lane_addr = 8'(base_d + 8'(32'(lane_d) * STRIDE));
      busy_d    = (state_d != S_IDLE);

      case (state_d)
         S_RD: begin
            mem_read_d = 1'b1;
            mem_addr_d = lane_addr;
            // Read data lags the address by one cycle, so lane i-1 captures now.
            if (lane_d != '0) begin
               vout_sel_d                     = 1'b1;
               t_ld_d[lane_d - LANE_W'(1)]    = 1'b1;
            end
         end
         S_CAP: begin
            vout_sel_d = 1'b1;
            t_ld_d     = 4'b1000;
         end
         S_WB: begin
            vrf_write_d = 1'b1;
            done_d      = 1'b1;
         end
         S_LDX:   x1_load_d = 1'b1;
         S_WR: begin
            mem_write_d  = 1'b1;
            mem_addr_d   = lane_addr;
            mem_in_sel_d = 3'(lane_d);
            done_d       = (lane_d == LAST_LANE);
         end
         S_ADDX: begin
            x1_load_d = 1'b1;
            x2_load_d = 1'b1;
         end
         S_ADDT:  t_ld_d = 4'b1111;
         S_ADDWB: begin
            vrf_write_d = 1'b1;
            done_d      = 1'b1;
         end
         default: ;
      endcase
   end

   // State, lane counter, latched base and registered outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         lane_q     <= '0;
         base_q     <= 8'h00;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         mem_addr   <= 8'h00;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         mem_in_sel <= 3'd0;
         x1_load    <= 1'b0;
         x2_load    <= 1'b0;
         vout_sel   <= 1'b0;
         t_ld       <= 4'b0000;
         vrf_write  <= 1'b0;
      end else begin
         state_q    <= state_d;
         lane_q     <= lane_d;
         base_q     <= base_d;
         busy       <= busy_d;
         done       <= done_d;
         err        <= err_d;
         mem_addr   <= mem_addr_d;
         mem_read   <= mem_read_d;
         mem_write  <= mem_write_d;
         mem_in_sel <= mem_in_sel_d;
         x1_load    <= x1_load_d;
         x2_load    <= x2_load_d;
         vout_sel   <= vout_sel_d;
         t_ld       <= t_ld_d;
         vrf_write  <= vrf_write_d;
      end
   end

endmodule
